wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back consumer for the MEM/WB pipeline register: a 32 x 32-bit integer register file whose single write port takes the MEM/WB register outputs directly, plus two registered read ports that feed the ID/EX boundary. Reads and writes to the same register in the same cycle resolve write-first, so decode never sees stale data from an instruction retiring in WB. Also keeps a free-running count of committed register writes for debug and performance checks.

## Interface
Parameters:
- REG_W, 32, data width of each register
- ADDR_W, 5, register address width (2^ADDR_W registers)

Ports:
- clock  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock
- d2_in  input  REG_W  write-back data from the MEM/WB register
- rd_in  input  ADDR_W  write-back destination register
- c_m_w_in  input  32  control word from the MEM/WB register; bit 20 = register-write enable, other bits ignored
- stall  input  1  freeze read outputs (decode hold)
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  REG_W  registered read port A data
- rt_data  output  REG_W  registered read port B data
- wr_count  output  32  number of committed register writes, wrapping

## Operation
- Commit condition: `we = c_m_w_in[20] && (rd_in != 0)`. When `we` is high, `regs[rd_in] <= d2_in` on the edge.
- Register 0 is never written. It always reads 0, including when a write targets it.
- Read port A behaves as follows when stall = 0; port B is identical with rt_addr:
  - rs_addr == 0 → 0
  - else if we and rd_in == rs_addr → d2_in (write-first bypass)
  - else → regs[rs_addr]
- Both ports may hit the same address, and may both bypass in the same cycle.
- stall = 1: rs_data and rt_data hold their values. Writes and wr_count are unaffected by stall.
- wr_count increments by 1 on every edge where we = 1. It wraps from 0xFFFFFFFF to 0x00000000. Writes to r0 suppressed by the commit condition are not counted.
- Reset dominates everything on the same edge:
  - all registers, rs_data, rt_data and wr_count go to 0
  - a coincident write is discarded and not counted
  - a coincident stall is ignored
- Reset mid-operation drops any in-flight write. The contents after reset are all-zero regardless of history.

## Timing
- Reset values: rs_data = 0, rt_data = 0, wr_count = 0, all regs = 0.
- Write latency: data is visible in regs after 1 edge.
- Read latency: 1 cycle. An address applied before edge N appears on the data output after edge N.
- Bypass: a write and a read of the same nonzero register in the same cycle produce the new value at the read output after the same edge, with 0 extra cycles.
- Outputs are pure flops. There is no combinational path from any input to any output.
- No handshake. The write port is always accepted, and there is no backpressure toward MEM/WB.

## Structure
- Shared package (`pipeline_pkg`) holds:
  - CMW_REG_WRITE = 20 (control-word bit index)
  - REG_W and ADDR_W defaults
  - ZERO_REG = 0

  mem_wb and this block both reference the same bit index.
- One sub-module is natural: `regfile_bank`, the storage array with one write port and two asynchronous read ports. It contains no r0 logic.
- The top level holds the commit condition, bypass mux, r0 forcing, output flops, stall hold and counter.
- Target size: about 150 to 200 lines total.

## Test plan
- Reset, then write: assert reset for 2 cycles, then write 0xDEADBEEF to r5 with c_m_w_in = 0x00100000 and rd_in = 5. Read r5 next cycle. Required: rs_data = 0xDEADBEEF and wr_count = 1. Before the write, every register reads 0.
- r0 protection: write 0x12345678 with rd_in = 0 and bit 20 = 1, then read r0 on both ports. Required: both ports = 0 and wr_count unchanged.
- Same-cycle bypass: r7 = 0x11111111, then write 0x22222222 to r7 while rs_addr = rt_addr = 7. Required: both outputs = 0x22222222 after that edge, not 0x11111111.
- Stall hold: rs_data = 0xAAAA0000, raise stall, change rs_addr, and write 0x5 to r3 during the stall. Required: rs_data stays 0xAAAA0000 while stalled. After stall drops, reading r3 gives 0x5.
- Write disabled and counter wrap:
  - bit 20 = 0 with rd_in = 9 and data 0xFF: r9 unchanged and no count.
  - Force wr_count to 0xFFFFFFFF via 2^32-1 writes, or a backdoor preload in simulation only, then perform one write: wr_count = 0.
- Reset mid-write: assert reset on the same edge as a write of 0x1 to r4. Required: r4 reads 0, wr_count = 0, and both outputs = 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word bit positions and datapath defaults
// used by both the MEM/WB register and the write-back register file.
package pipeline_pkg;

   // Register-write enable position inside the MEM/WB control word
   localparam int CMW_REG_WRITE = 20;

   // Datapath defaults for the integer register file
   localparam int DEF_REG_W  = 32;
   localparam int DEF_ADDR_W = 5;

   // Hard-wired zero register
   localparam int ZERO_REG = 0;

   // True when a control word asks for a register write
   function automatic logic cmw_reg_write(input logic [31:0] cmw);
      return cmw[CMW_REG_WRITE];
   endfunction

endpackage

// File: rtl/regfile_bank.sv
// Plain storage array: one synchronous write port, two asynchronous read ports.
// Knows nothing about r0; the caller keeps r0 untouched by never writing it.
module regfile_bank
   import pipeline_pkg::*;
#(
   parameter int REG_W  = DEF_REG_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [REG_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [REG_W-1:0]  rdata_a,
   output logic [REG_W-1:0]  rdata_b
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [REG_W-1:0] mem_q [DEPTH];

   // Storage update: reset clears every entry, otherwise write the addressed one
   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: commits MEM/WB results, serves two registered
// read ports with write-first bypass, and counts committed writes.
module wb_regfile
   import pipeline_pkg::*;
#(
   parameter int REG_W  = DEF_REG_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_W-1:0]  d2_in,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [31:0]       c_m_w_in,
   input  logic              stall,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [REG_W-1:0]  rs_data,
   output logic [REG_W-1:0]  rt_data,
   output logic [31:0]       wr_count
);

   localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

   logic             we;
   logic [REG_W-1:0] bank_rs, bank_rt;
   logic [REG_W-1:0] rs_data_q, rs_data_d;
   logic [REG_W-1:0] rt_data_q, rt_data_d;
   logic [31:0]      wr_count_q, wr_count_d;

   // Only bit CMW_REG_WRITE of the control word matters here
   logic unused_cmw;
   assign unused_cmw = ^{c_m_w_in[31:CMW_REG_WRITE+1], c_m_w_in[CMW_REG_WRITE-1:0]};

   // A write to r0 is dropped entirely, so r0 storage stays at its reset zero
   assign we = cmw_reg_write(c_m_w_in) && (rd_in != R0);

   regfile_bank #(
      .REG_W  (REG_W),
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk     (clock),
      .srst    (reset),
      .we      (we),
      .waddr   (rd_in),
      .wdata   (d2_in),
      .raddr_a (rs_addr),
      .raddr_b (rt_addr),
      .rdata_a (bank_rs),
      .rdata_b (bank_rt)
   );

   // Next read data: hold on stall, force r0 to zero, bypass a same-cycle write
   always_comb begin
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      wr_count_d = wr_count_q + (we ? 32'd1 : 32'd0);
      if (!stall) begin
         if (rs_addr == R0)               rs_data_d = '0;
         else if (we && rd_in == rs_addr) rs_data_d = d2_in;
         else                             rs_data_d = bank_rs;

         if (rt_addr == R0)               rt_data_d = '0;
         else if (we && rd_in == rt_addr) rt_data_d = d2_in;
         else                             rt_data_d = bank_rt;
      end
   end

   // Output flops and commit counter; reset wins over stall and writes
   always_ff @(posedge clock) begin
      if (reset) begin
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         wr_count_q <= '0;
      end else begin
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rs_data  = rs_data_q;
   assign rt_data  = rt_data_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios followed by random traffic, all
// compared every cycle against an array-based reference model.
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic [31:0] d2_in;
   logic [4:0]  rd_in;
   logic [31:0] c_m_w_in;
   logic        stall;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wr_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_rs, m_rt, m_cnt;

   localparam logic [31:0] WEN = 32'h0010_0000;

   wb_regfile dut (
      .clock    (clk),
      .reset    (reset),
      .d2_in    (d2_in),
      .rd_in    (rd_in),
      .c_m_w_in (c_m_w_in),
      .stall    (stall),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: reset clears everything; otherwise the write lands first and the
   // read ports then sample the updated array (r0 is never written).
   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_rs  = '0;
         m_rt  = '0;
         m_cnt = '0;
      end else begin
         if (c_m_w_in[20] && rd_in != 5'd0) begin
            m_regs[rd_in] = d2_in;
            m_cnt         = m_cnt + 32'd1;
         end
         if (!stall) begin
            m_rs = m_regs[rs_addr];
            m_rt = m_regs[rt_addr];
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, compare at the next falling edge
   task automatic cyc(input string tag, input logic rst, input logic [31:0] d,
                      input logic [4:0] rd, input logic [31:0] cmw, input logic st,
                      input logic [4:0] ra, input logic [4:0] rb);
      reset = rst; d2_in = d; rd_in = rd; c_m_w_in = cmw; stall = st;
      rs_addr = ra; rt_addr = rb;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, ".rs"}, rs_data, m_rs);
      chk({tag, ".rt"}, rt_data, m_rt);
      chk({tag, ".cnt"}, wr_count, m_cnt);
      $display("cyc %-10s rst=%0b we=%0b rd=%0d d=%h st=%0b ra=%0d rb=%0d -> rs=%h rt=%h cnt=%0d",
               tag, rst, cmw[20], rd, d, st, ra, rb, rs_data, rt_data, wr_count);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 'x;
      m_rs = 'x; m_rt = 'x; m_cnt = 'x;
      reset = 1'b1; d2_in = '0; rd_in = '0; c_m_w_in = '0; stall = 1'b0;
      rs_addr = '0; rt_addr = '0;
      @(negedge clk);

      // Reset for two cycles, then every register must read zero
      cyc("reset0", 1'b1, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      cyc("reset1", 1'b1, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      chk("rst_rs", rs_data, 32'h0);
      chk("rst_cnt", wr_count, 32'h0);
      for (int i = 0; i < 16; i++)
         cyc("readzero", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'(2*i), 5'(2*i+1));

      // Write r5, read it back
      cyc("wr_r5", 1'b0, 32'hDEADBEEF, 5'd5, WEN, 1'b0, 5'd0, 5'd0);
      cyc("rd_r5", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
      chk("r5_val", rs_data, 32'hDEADBEEF);
      chk("r5_cnt", wr_count, 32'd1);

      // r0 is immune to writes and is not counted
      cyc("wr_r0", 1'b0, 32'h12345678, 5'd0, WEN, 1'b0, 5'd0, 5'd0);
      cyc("rd_r0", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      chk("r0_rs", rs_data, 32'h0);
      chk("r0_rt", rt_data, 32'h0);
      chk("r0_cnt", wr_count, 32'd1);
      cyc("wr_r0_rd", 1'b0, 32'h12345678, 5'd0, WEN, 1'b0, 5'd0, 5'd0);
      chk("r0_byp", rs_data, 32'h0);

      // Same-cycle bypass on both ports
      cyc("wr_r7a", 1'b0, 32'h11111111, 5'd7, WEN, 1'b0, 5'd0, 5'd0);
      cyc("wr_r7b", 1'b0, 32'h22222222, 5'd7, WEN, 1'b0, 5'd7, 5'd7);
      chk("byp_rs", rs_data, 32'h22222222);
      chk("byp_rt", rt_data, 32'h22222222);

      // Stall holds outputs while a write still commits
      cyc("wr_r2", 1'b0, 32'hAAAA0000, 5'd2, WEN, 1'b0, 5'd0, 5'd0);
      cyc("rd_r2", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd2, 5'd2);
      cyc("stall_w", 1'b0, 32'h5, 5'd3, WEN, 1'b1, 5'd3, 5'd3);
      chk("stall_rs0", rs_data, 32'hAAAA0000);
      cyc("stall_h", 1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3);
      chk("stall_rs1", rs_data, 32'hAAAA0000);
      cyc("unstall", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd2);
      chk("r3_val", rs_data, 32'h5);

      // Write enable low: no write, no count
      cyc("wr_dis", 1'b0, 32'hFF, 5'd9, 32'hFFEF_FFFF, 1'b0, 5'd9, 5'd0);
      cyc("rd_r9", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd0);
      chk("r9_val", rs_data, 32'h0);

      // Counter wrap via simulation-only preload
      force dut.wr_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count_q;
      m_cnt = 32'hFFFF_FFFF;
      chk("preload", wr_count, 32'hFFFF_FFFF);
      @(negedge clk);
      cyc("wrap", 1'b0, 32'h77, 5'd10, WEN, 1'b0, 5'd0, 5'd0);
      chk("wrap_cnt", wr_count, 32'h0);

      // Random traffic with occasional stall and reset
      for (int n = 0; n < 400; n++) begin
         cyc("rand", ($urandom_range(0, 49) == 0), $urandom,
             5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) != 0) ? ($urandom | WEN) : ($urandom & ~WEN),
             ($urandom_range(0, 7) == 0),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      // Reset coincident with a write drops it
      cyc("rst_wr", 1'b1, 32'h1, 5'd4, WEN, 1'b1, 5'd4, 5'd4);
      chk("rstw_rs", rs_data, 32'h0);
      chk("rstw_cnt", wr_count, 32'h0);
      cyc("rd_r4", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd7);
      chk("r4_val", rs_data, 32'h0);
      chk("r7_clr", rt_data, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
